// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 line port between I- and D-cache
// miss paths with registered grant, latched request and starvation aging.
module l2_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pmem_read,
  input  logic [31:0]      i_pmem_address,
  output logic [255:0]     i_pmem_rdata,
  output logic             i_pmem_resp,
  input  logic             d_pmem_read,
  input  logic             d_pmem_write,
  input  logic [31:0]      d_pmem_address,
  input  logic [255:0]     d_pmem_wdata,
  output logic [255:0]     d_pmem_rdata,
  output logic             d_pmem_resp,
  output logic             a_pmem_read,
  output logic             a_pmem_write,
  output logic [31:0]      a_pmem_address,
  output logic [255:0]     a_pmem_wdata,
  input  logic [255:0]     a_pmem_rdata,
  input  logic             a_pmem_resp,
  output logic [CNT_W-1:0] i_grant_count,
  output logic [CNT_W-1:0] d_grant_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  state_t state, state_n;

  logic             rd_n;
  logic             wr_n;
  logic [31:0]      addr_n;
  logic [255:0]     wdata_n;
  logic [SW-1:0]    starve, starve_n;
  logic [CNT_W-1:0] icnt_n;
  logic [CNT_W-1:0] dcnt_n;
  logic             d_req;
  logic             i_win;
  logic             d_win;

  // Line data fans out unconditionally; only the completion is steered.
  assign i_pmem_rdata = a_pmem_rdata;
  assign d_pmem_rdata = a_pmem_rdata;
  assign i_pmem_resp  = (state == SERVE_I) & a_pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & a_pmem_resp;

  // Next-state, arbitration and latch-enable logic.
  always_comb begin
    state_n  = state;
    rd_n     = a_pmem_read;
    wr_n     = a_pmem_write;
    addr_n   = a_pmem_address;
    wdata_n  = a_pmem_wdata;
    starve_n = starve;
    icnt_n   = i_grant_count;
    dcnt_n   = d_grant_count;
    d_req    = d_pmem_read | d_pmem_write;
    // D normally wins a tie; an aged I request takes the next slot.
    i_win    = i_pmem_read & (~d_req | (starve == LIMIT));
    d_win    = d_req & ~i_win;
    case (state)
      IDLE: begin
        unique case (1'b1)
          i_win: begin
            state_n  = SERVE_I;
            rd_n     = 1'b1;
            wr_n     = 1'b0;
            addr_n   = i_pmem_address;
            starve_n = '0;
            if (i_grant_count != '1)
              icnt_n = i_grant_count + 1'b1;
          end
          d_win: begin
            state_n = SERVE_D;
            // Write wins if a D cache ever raises both.
            rd_n    = ~d_pmem_write;
            wr_n    = d_pmem_write;
            addr_n  = d_pmem_address;
            wdata_n = d_pmem_wdata;
            if (i_pmem_read && starve != LIMIT)
              starve_n = starve + 1'b1;
            if (d_grant_count != '1)
              dcnt_n = d_grant_count + 1'b1;
          end
          default: ;
        endcase
      end
      SERVE_I, SERVE_D: begin
        if (a_pmem_resp) begin
          state_n = IDLE;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
      end
    endcase
  end

  // State, latched request and counters, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      a_pmem_read    <= 1'b0;
      a_pmem_write   <= 1'b0;
      a_pmem_address <= '0;
      a_pmem_wdata   <= '0;
      starve         <= '0;
      i_grant_count  <= '0;
      d_grant_count  <= '0;
    end else begin
      state          <= state_n;
      a_pmem_read    <= rd_n;
      a_pmem_write   <= wr_n;
      a_pmem_address <= addr_n;
      a_pmem_wdata   <= wdata_n;
      starve         <= starve_n;
      i_grant_count  <= icnt_n;
      d_grant_count  <= dcnt_n;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed stimulus with a scoreboard of expected L2
// transactions checked by an independent monitor on the falling edge.
module tb_l2_port_arbiter;

  typedef struct {
    logic         side;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    int           len;
    int           gap;
  } exp_t;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } dreq_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_pmem_read = 1'b0;
  logic [31:0]  i_pmem_address = '0;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [31:0]  d_pmem_address = '0;
  logic [255:0] d_pmem_wdata = '0;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         a_pmem_read;
  logic         a_pmem_write;
  logic [31:0]  a_pmem_address;
  logic [255:0] a_pmem_wdata;
  logic [255:0] l2_rdata = '0;
  logic         a_pmem_resp = 1'b0;
  logic [31:0]  i_grant_count;
  logic [31:0]  d_grant_count;

  exp_t         sb[$];
  logic [31:0]  iq[$];
  dreq_t        dq[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           lat = 2;
  logic         stray = 1'b0;
  logic         d_ovr_en = 1'b0;
  logic [31:0]  d_ovr = '0;
  int           i_resp_cnt = 0;
  int           d_resp_cnt = 0;
  logic         in_txn = 1'b0;

  always #5 clk = ~clk;

  l2_port_arbiter #(.STARVE_LIMIT(8), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .i_pmem_read(i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata),
    .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata),
    .d_pmem_resp(d_pmem_resp),
    .a_pmem_read(a_pmem_read),
    .a_pmem_write(a_pmem_write),
    .a_pmem_address(a_pmem_address),
    .a_pmem_wdata(a_pmem_wdata),
    .a_pmem_rdata(l2_rdata),
    .a_pmem_resp(a_pmem_resp),
    .i_grant_count(i_grant_count),
    .d_grant_count(d_grant_count)
  );

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic side, input logic wr,
                          input logic [31:0] addr, input logic [255:0] wd,
                          input logic [255:0] rd, input int gap);
    exp_t e;
    e.side = side;
    e.wr = wr;
    e.addr = addr;
    e.wdata = wd;
    e.rdata = rd;
    e.len = lat;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_d(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [255:0] wd);
    dreq_t r;
    r.rd = rd;
    r.wr = wr;
    r.addr = addr;
    r.wdata = wd;
    dq.push_back(r);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while ((sb.size() != 0 || in_txn || iq.size() != 0 || dq.size() != 0)
           && k < budget) begin
      step();
      k++;
    end
    n_vec++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic wait_active(input string name, input int budget);
    int k = 0;
    while (!(a_pmem_read || a_pmem_write) && k < budget) begin
      step();
      k++;
    end
    n_vec++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: got idle want active", name);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Requesters: present the queue head, retire it after its completion.
  initial begin
    int ip = 0;
    int dp = 0;
    forever begin
      @(posedge clk);
      #1;
      while (ip < i_resp_cnt) begin
        if (iq.size() != 0) iq.delete(0);
        ip++;
      end
      while (dp < d_resp_cnt) begin
        if (dq.size() != 0) dq.delete(0);
        dp++;
      end
      i_pmem_read = iq.size() != 0;
      i_pmem_address = (iq.size() != 0) ? iq[0] : 32'h0;
      d_pmem_read = (dq.size() != 0) ? dq[0].rd : 1'b0;
      d_pmem_write = (dq.size() != 0) ? dq[0].wr : 1'b0;
      d_pmem_wdata = (dq.size() != 0) ? dq[0].wdata : '0;
      d_pmem_address = d_ovr_en ? d_ovr :
                       (dq.size() != 0) ? dq[0].addr : 32'h0;
    end
  end

  // L2 model: completes after lat active cycles; can inject a stray resp.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cnt = 0;
        a_pmem_resp = 1'b0;
      end else if (a_pmem_read || a_pmem_write) begin
        cnt++;
        a_pmem_resp = (cnt == lat);
      end else begin
        cnt = 0;
        a_pmem_resp = stray;
      end
    end
  end

  // Monitor: pops the scoreboard on each new L2 transaction.
  initial begin
    exp_t cur;
    int   len = 0;
    int   gap = 0;
    logic gap_known = 1'b0;
    logic act;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 1'b0;
        gap_known = 1'b0;
      end else begin
        if (i_pmem_resp) i_resp_cnt++;
        if (d_pmem_resp) d_resp_cnt++;
        chk("resp_excl", i_pmem_resp & d_pmem_resp, 1'b0);
        act = a_pmem_read | a_pmem_write;
        if (act && !in_txn) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_txn: got addr %h want none",
                     a_pmem_address);
            cur.side = 1'b0;
            cur.wr = a_pmem_write;
            cur.addr = a_pmem_address;
            cur.wdata = a_pmem_wdata;
            cur.rdata = '0;
            cur.len = 1;
            cur.gap = -1;
          end else begin
            cur = sb.pop_front();
          end
          in_txn = 1'b1;
          len = 0;
          chk("op_write", a_pmem_write, cur.wr);
          chk("op_read", a_pmem_read, !cur.wr);
          chk("addr", a_pmem_address, cur.addr);
          chk("wdata", a_pmem_wdata, cur.wdata);
          if (cur.gap >= 0 && gap_known) chk("idle_gap", gap, cur.gap);
        end else if (act) begin
          chk("hold_write", a_pmem_write, cur.wr);
          chk("hold_read", a_pmem_read, !cur.wr);
          chk("hold_addr", a_pmem_address, cur.addr);
          chk("hold_wdata", a_pmem_wdata, cur.wdata);
        end else if (in_txn) begin
          chk("early_drop", 1'b0, 1'b1);
          in_txn = 1'b0;
        end else begin
          gap++;
        end
        if (in_txn) begin
          len++;
          if (a_pmem_resp) begin
            chk("txn_len", len, cur.len);
            chk("i_resp", i_pmem_resp, !cur.side);
            chk("d_resp", d_pmem_resp, cur.side);
            chk("rdata", cur.side ? d_pmem_rdata : i_pmem_rdata, cur.rdata);
            in_txn = 1'b0;
            gap = 0;
            gap_known = 1'b1;
          end
        end else if (a_pmem_resp) begin
          chk("stray_i_resp", i_pmem_resp, 1'b0);
          chk("stray_d_resp", d_pmem_resp, 1'b0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w1, w2, w3, w5, w6, w7, r1, r2, r3, r5, a5;
    logic [7:0]   kb;
    w1 = {8{32'h1111_2222}};
    w2 = {8{32'hC0DE_F00D}};
    w3 = {8{32'h3333_4444}};
    w5 = {8{32'h5555_0001}};
    w6 = {8{32'h6666_0002}};
    w7 = {8{32'h7777_0003}};
    r1 = {8{32'hFEED_0001}};
    r2 = {8{32'hFEED_0002}};
    r3 = {8{32'hFEED_0003}};
    r5 = {8{32'hFEED_0005}};
    a5 = {32{8'hA5}};

    // Both requesters up while reset is held.
    lat = 2;
    l2_rdata = r1;
    push_d(1'b1, 1'b0, 32'h0000_2000, w1);
    iq.push_back(32'h0000_3000);
    push_exp(1'b1, 1'b0, 32'h0000_2000, w1, r1, -1);
    push_exp(1'b0, 1'b0, 32'h0000_3000, w1, r1, 1);
    step();
    step();
    step();
    chk("rst_a_read", a_pmem_read, 1'b0);
    chk("rst_a_write", a_pmem_write, 1'b0);
    chk("rst_a_addr", a_pmem_address, 32'h0);
    chk("rst_a_wdata", a_pmem_wdata, '0);
    chk("rst_i_resp", i_pmem_resp, 1'b0);
    chk("rst_d_resp", d_pmem_resp, 1'b0);
    chk("rst_i_cnt", i_grant_count, 32'd0);
    chk("rst_d_cnt", d_grant_count, 32'd0);
    rst = 1'b0;
    chk("post_rst_idle", a_pmem_read, 1'b0);
    step();
    chk("first_grant_read", a_pmem_read, 1'b1);
    chk("first_grant_addr", a_pmem_address, 32'h0000_2000);
    wait_done("t1", 100);
    chk("t1_i_cnt", i_grant_count, 32'd1);
    chk("t1_d_cnt", d_grant_count, 32'd1);

    // I-only read, three-cycle L2 latency.
    do_reset();
    lat = 3;
    l2_rdata = a5;
    iq.push_back(32'h0000_1000);
    push_exp(1'b0, 1'b0, 32'h0000_1000, '0, a5, -1);
    wait_done("t2", 100);
    chk("t2_i_cnt", i_grant_count, 32'd1);
    chk("t2_d_cnt", d_grant_count, 32'd0);

    // D write; requester address moves while the write is in flight.
    lat = 4;
    l2_rdata = r2;
    push_d(1'b0, 1'b1, 32'h8000_0040, w2);
    push_exp(1'b1, 1'b1, 32'h8000_0040, w2, r2, -1);
    wait_active("t3", 50);
    step();
    d_ovr = 32'hDEAD_0000;
    d_ovr_en = 1'b1;
    wait_done("t3", 100);
    d_ovr_en = 1'b0;
    chk("t3_d_cnt", d_grant_count, 32'd1);

    // Continuous contention: eight D grants, then I, then D again.
    do_reset();
    lat = 1;
    l2_rdata = r3;
    iq.push_back(32'h0000_4000);
    for (int k = 0; k < 10; k++) begin
      kb = 8'(k);
      push_d(1'b1, 1'b0, 32'h0001_0000 + 32'(k * 64), {32{kb}});
    end
    for (int k = 0; k < 10; k++) begin
      kb = 8'(k);
      if (k == 8) push_exp(1'b0, 1'b0, 32'h0000_4000, {32{8'h07}}, r3, 1);
      push_exp(1'b1, 1'b0, 32'h0001_0000 + 32'(k * 64), {32{kb}}, r3,
               (k == 0) ? -1 : 1);
    end
    begin
      int k = 0;
      while (!i_pmem_resp && k < 200) begin
        step();
        k++;
      end
      chk("t4_i_resp_seen", i_pmem_resp, 1'b1);
    end
    chk("t4_d_cnt_at_i", d_grant_count, 32'd8);
    chk("t4_i_cnt_at_i", i_grant_count, 32'd1);
    wait_done("t4", 200);
    chk("t4_d_cnt_end", d_grant_count, 32'd10);
    chk("t4_i_cnt_end", i_grant_count, 32'd1);

    // Reset lands mid-transaction; a late L2 resp must be swallowed.
    lat = 10;
    push_d(1'b1, 1'b0, 32'h0000_9000, w3);
    push_exp(1'b1, 1'b0, 32'h0000_9000, w3, r3, -1);
    wait_active("t5", 50);
    step();
    step();
    rst = 1'b1;
    dq.delete();
    step();
    step();
    rst = 1'b0;
    step();
    stray = 1'b1;
    step();
    chk("t5_i_resp", i_pmem_resp, 1'b0);
    chk("t5_d_resp", d_pmem_resp, 1'b0);
    chk("t5_a_read", a_pmem_read, 1'b0);
    chk("t5_a_write", a_pmem_write, 1'b0);
    chk("t5_i_cnt", i_grant_count, 32'd0);
    chk("t5_d_cnt", d_grant_count, 32'd0);
    stray = 1'b0;
    step();

    // Read+write together issues a write; back-to-back D traffic.
    lat = 2;
    l2_rdata = r5;
    push_d(1'b1, 1'b1, 32'h0000_5000, w5);
    push_d(1'b1, 1'b0, 32'h0000_5040, w6);
    push_d(1'b0, 1'b1, 32'h0000_5080, w7);
    push_exp(1'b1, 1'b1, 32'h0000_5000, w5, r5, -1);
    push_exp(1'b1, 1'b0, 32'h0000_5040, w6, r5, 1);
    push_exp(1'b1, 1'b1, 32'h0000_5080, w7, r5, 1);
    wait_done("t6", 100);
    chk("t6_d_cnt", d_grant_count, 32'd3);
    chk("t6_i_cnt", i_grant_count, 32'd0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single 256-bit L2 request port between the I-cache and D-cache miss paths.
- Replaces the split control/datapath arbiter pair with one registered block: grant FSM, latched address/data, response steering, starvation aging and grant counters.
- Sits between the two L1 caches and l2_cache in cache_sys.

Parameters:
STARVE_LIMIT, 8, consecutive cycles of pending I-request lost to D before I is forced to win the next arbitration
CNT_W, 32, width of the saturating grant counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
i_pmem_address  in  32  I-cache line address
i_pmem_rdata  out  256  line data to I-cache
i_pmem_resp  out  1  I-cache completion pulse
d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp
d_pmem_write  in  1  D-cache writeback request, held until d_pmem_resp
d_pmem_address  in  32  D-cache line address
d_pmem_wdata  in  256  D-cache writeback line
d_pmem_rdata  out  256  line data to D-cache
d_pmem_resp  out  1  D-cache completion pulse
a_pmem_read  out  1  read to L2
a_pmem_write  out  1  write to L2
a_pmem_address  out  32  latched address to L2
a_pmem_wdata  out  256  latched write line to L2
a_pmem_rdata  in  256  line data from L2
a_pmem_resp  in  1  L2 completion
i_grant_count  out  CNT_W  I grants issued, saturating
d_grant_count  out  CNT_W  D grants issued, saturating

Behaviour:
- Reset (synchronous, active-high): state=IDLE. a_pmem_read/write=0. a_pmem_address=0, a_pmem_wdata=0. Both resps=0. Starvation counter=0. Both grant counters=0.
- Reset mid-transaction: the in-flight request is abandoned. An a_pmem_resp arriving later in IDLE is ignored and no L1 resp is produced.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE arbitration (cycle N), with d_req = d_pmem_read | d_pmem_write:
  - If d_req and i_pmem_read: D wins unless starve_cnt == STARVE_LIMIT, in which case I wins.
  - Single requester wins outright. No request: stay in IDLE.
- On grant, the winner's address is latched into a_pmem_address; for D, d_pmem_wdata is also latched into a_pmem_wdata.
  - D op: write if d_pmem_write, else read. Write takes precedence if both are asserted, which is a protocol violation but defined this way.
  - I op: always read. a_pmem_wdata is unchanged.
  - The winner's grant counter increments, saturating at all-ones.
- SERVE_x, from cycle N+1: a_pmem_read or a_pmem_write is high (registered), with address and wdata stable, until the cycle a_pmem_resp=1.
  - In that cycle the winner's resp=1 combinationally, and its rdata = a_pmem_rdata (used on reads; driven on writes too).
  - Next state is IDLE, with a_pmem_read/write low the following cycle. There is always at least one IDLE cycle between transactions.
- i_pmem_rdata and d_pmem_rdata are driven from a_pmem_rdata at all times; only the resp is gated.
- Requester inputs that change during SERVE have no effect.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each IDLE-arbitration cycle where i_pmem_read=1 and D is granted.
  - Clears on every I grant.
  - Holds otherwise.
- Minimum transaction latency: request cycle N, a_pmem_read at N+1; if L2 responds at N+1, the L1 resp is at N+1 and the next grant is possible at N+2.
- Non-winner resp is never asserted. i_pmem_resp and d_pmem_resp are never high in the same cycle.

Test Plan:
- Reset with both requests high → all outputs 0 during reset; first cycle after rst=0 is IDLE; D granted; a_pmem_read=1 one cycle later.
- I-only read of 0x0000_1000, L2 resp after 3 cycles with rdata=256'hA5.. → a_pmem_address=0x1000, a_pmem_read high 3 cycles, i_pmem_resp single pulse, i_pmem_rdata=256'hA5.., i_grant_count=1.
- D write to 0x8000_0040 with wdata pattern; address changed to 0xDEAD_0000 mid-SERVE → a_pmem_write=1 with address 0x8000_0040; d_pmem_resp pulse; a_pmem_read=0 throughout.
- I and D requesting continuously, STARVE_LIMIT=8 → D wins 8 arbitrations, I wins the 9th, then D resumes; counters read d=8, i=1 after 9 grants.
- rst asserted while in SERVE_D, then stray a_pmem_resp in IDLE → no d_pmem_resp or i_pmem_resp; state IDLE; grant counters 0.
- d_pmem_read and d_pmem_write both high, plus back-to-back D requests → write issued; exactly one IDLE cycle (a_pmem_read/write low) between consecutive transactions.
